// File: rtl/rect_detect_if.sv
// VGA pixel-stream bundle: beam position, sync/blanking flags and RGB444 colour.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/rect_detect.sv
// Key-colour bounding box and pixel counter, reported once per frame on the vblnk rise.
// The VGA stream passes through with a single register stage and is never modified.
module rect_detect #(
  parameter logic [11:0] KEY_COLOR = 12'h0ba,
  parameter logic [11:0] KEY_MASK  = 12'hfff
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           in,
  vga_if.out          out,
  output logic        box_valid,
  output logic        box_found,
  output logic [10:0] x_min,
  output logic [10:0] x_max,
  output logic [10:0] y_min,
  output logic [10:0] y_max,
  output logic [19:0] pix_cnt
);

  typedef enum logic {SYNC, ACCUM} state_t;

  localparam logic [10:0] MIN_INIT = 11'h7ff;
  localparam logic [19:0] CNT_MAX  = 20'hf_ffff;

  state_t      state;
  logic        prev_vblnk;
  logic        acc_found;
  logic [10:0] acc_x_min;
  logic [10:0] acc_x_max;
  logic [10:0] acc_y_min;
  logic [10:0] acc_y_max;
  logic [19:0] acc_cnt;

  logic active;
  logic match;
  logic hit;
  logic frame_end;

  assign active    = !in.hblnk && !in.vblnk;
  assign match     = (in.rgb & KEY_MASK) == (KEY_COLOR & KEY_MASK);
  assign hit       = active && match;
  assign frame_end = in.vblnk && !prev_vblnk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out.vcount <= '0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hcount <= '0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.vcount <= in.vcount;
      out.vsync  <= in.vsync;
      out.vblnk  <= in.vblnk;
      out.hcount <= in.hcount;
      out.hsync  <= in.hsync;
      out.hblnk  <= in.hblnk;
      out.rgb    <= in.rgb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SYNC;
      prev_vblnk <= 1'b0;
      acc_found  <= 1'b0;
      acc_x_min  <= MIN_INIT;
      acc_x_max  <= '0;
      acc_y_min  <= MIN_INIT;
      acc_y_max  <= '0;
      acc_cnt    <= '0;
      box_valid  <= 1'b0;
      box_found  <= 1'b0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      pix_cnt    <= '0;
    end else begin
      prev_vblnk <= in.vblnk;
      box_valid  <= 1'b0;
      case (state)
        SYNC: begin
          // The frame in progress at reset release is partial, so it is dropped.
          if (frame_end) begin
            state     <= ACCUM;
            acc_found <= 1'b0;
            acc_x_min <= MIN_INIT;
            acc_x_max <= '0;
            acc_y_min <= MIN_INIT;
            acc_y_max <= '0;
            acc_cnt   <= '0;
          end
        end
        ACCUM: begin
          if (frame_end) begin
            // An empty frame reports zeros, never the min sentinels.
            box_valid <= 1'b1;
            box_found <= acc_found;
            x_min     <= acc_found ? acc_x_min : '0;
            x_max     <= acc_found ? acc_x_max : '0;
            y_min     <= acc_found ? acc_y_min : '0;
            y_max     <= acc_found ? acc_y_max : '0;
            pix_cnt   <= acc_cnt;
            acc_found <= 1'b0;
            acc_x_min <= MIN_INIT;
            acc_x_max <= '0;
            acc_y_min <= MIN_INIT;
            acc_y_max <= '0;
            acc_cnt   <= '0;
          end else if (hit) begin
            acc_found <= 1'b1;
            if (!acc_found) begin
              acc_x_min <= in.hcount;
              acc_x_max <= in.hcount;
              acc_y_min <= in.vcount;
              acc_y_max <= in.vcount;
            end else begin
              if (in.hcount < acc_x_min) acc_x_min <= in.hcount;
              if (in.hcount > acc_x_max) acc_x_max <= in.hcount;
              if (in.vcount < acc_y_min) acc_y_min <= in.vcount;
              if (in.vcount > acc_y_max) acc_y_max <= in.vcount;
            end
            if (acc_cnt != CNT_MAX) acc_cnt <= acc_cnt + 20'd1;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_detect.sv
// Directed bench for rect_detect: per-cycle comparison against a hit-list model plus literal report checks.
module tb_rect_detect;

  localparam logic [11:0] KEY  = 12'h0ba;
  localparam logic [11:0] MASK = 12'hff0;

  logic        clk;
  logic        rst;
  logic        box_valid;
  logic        box_found;
  logic [10:0] x_min;
  logic [10:0] x_max;
  logic [10:0] y_min;
  logic [10:0] y_max;
  logic [19:0] pix_cnt;

  vga_if vin ();
  vga_if vout ();

  rect_detect #(.KEY_COLOR(KEY), .KEY_MASK(MASK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (vin),
    .out       (vout),
    .box_valid (box_valid),
    .box_found (box_found),
    .x_min     (x_min),
    .x_max     (x_max),
    .y_min     (y_min),
    .y_max     (y_max),
    .pix_cnt   (pix_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Last report captured from the DUT, for the literal checks.
  int          rep_n = 0;
  logic        rep_found;
  logic [10:0] rep_x_min, rep_x_max, rep_y_min, rep_y_max;
  logic [19:0] rep_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [37:0] pack_in();
    return {vin.vcount, vin.vsync, vin.vblnk, vin.hcount, vin.hsync, vin.hblnk, vin.rgb};
  endfunction

  function automatic logic [37:0] pack_out();
    return {vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk, vout.rgb};
  endfunction

  // Model: collect hit coordinates of the current frame, reduce them at each vblnk rise.
  initial begin
    logic [37:0] snap;
    logic        m_prev;
    int          m_rises;
    int          hx[$];
    int          hy[$];
    logic        e_valid, e_found;
    int          e_xmin, e_xmax, e_ymin, e_ymax, e_cnt;
    snap = '0; m_prev = 1'b0; m_rises = 0;
    e_valid = 1'b0; e_found = 1'b0;
    e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_cnt = 0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        snap = '0; m_prev = 1'b0; m_rises = 0;
        hx.delete(); hy.delete();
        e_valid = 1'b0; e_found = 1'b0;
        e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_cnt = 0;
      end else begin
        snap = pack_in();
        e_valid = 1'b0;
        if (vin.vblnk && !m_prev) begin
          if (m_rises > 0) begin
            e_valid = 1'b1;
            e_found = hx.size() > 0;
            e_cnt   = (hx.size() > 20'hf_ffff) ? 20'hf_ffff : hx.size();
            e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
            if (e_found) begin
              e_xmin = hx.min()[0]; e_xmax = hx.max()[0];
              e_ymin = hy.min()[0]; e_ymax = hy.max()[0];
            end
          end
          hx.delete(); hy.delete();
          if (m_rises < 2) m_rises++;
        end else if (!vin.hblnk && !vin.vblnk && ((vin.rgb & MASK) == (KEY & MASK))) begin
          hx.push_back(int'(vin.hcount));
          hy.push_back(int'(vin.vcount));
        end
        m_prev = vin.vblnk;
      end
      @(negedge clk);
      if (rst) begin
        chk("pass_through", 64'(pack_out()), 64'(snap));
        chk("box_valid", 64'(box_valid), 64'(e_valid));
        chk("box_found", 64'(box_found), 64'(e_found));
        chk("x_min", 64'(x_min), 64'(e_xmin));
        chk("x_max", 64'(x_max), 64'(e_xmax));
        chk("y_min", 64'(y_min), 64'(e_ymin));
        chk("y_max", 64'(y_max), 64'(e_ymax));
        chk("pix_cnt", 64'(pix_cnt), 64'(e_cnt));
        if (box_valid) begin
          rep_n++;
          rep_found = box_found;
          rep_x_min = x_min; rep_x_max = x_max;
          rep_y_min = y_min; rep_y_max = y_max;
          rep_cnt   = pix_cnt;
        end
      end
    end
  end

  task automatic drive(input int x, input int y, input logic hb, input logic vb,
                       input logic hs, input logic vs, input logic [11:0] c);
    vin.hcount = 11'(x);
    vin.vcount = 11'(y);
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.rgb    = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] pix(input int mode, input int x, input int y, input logic blank);
    case (mode)
      1: return (!blank && x > 1 && x < 101 && y > 1 && y < 101) ? 12'h0ba : 12'h123;
      2: return (!blank && x == 799 && y == 599) ? 12'h0ba : 12'h0ca;
      3: return blank ? 12'h0ba : ((x == 10 && y == 20) ? 12'h0b5 : 12'h0ca);
      4: return (!blank && x >= 5 && x <= 9 && y >= 5 && y <= 9) ? 12'h0ba : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  // Active lines; the last line runs straight into vblank so its final pixel abuts the frame end.
  task automatic lines(input int mode, input int x0, input int x1, input int y0, input int y1, input int ylast);
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) drive(x, y, 1'b0, 1'b0, 1'b0, 1'b0, pix(mode, x, y, 1'b0));
      if (y != ylast)
        for (int x = x1 + 1; x <= x1 + 4; x++)
          drive(x, y, 1'b1, 1'b0, x == x1 + 2, 1'b0, pix(mode, x, y, 1'b1));
    end
  endtask

  task automatic vblank(input int mode, input int x0, input int x1, input int ylast);
    for (int y = ylast + 1; y <= ylast + 2; y++)
      for (int x = x0; x <= x1 + 4; x++)
        drive(x, y, x > x1, 1'b1, x == x1 + 2, y == ylast + 1, pix(mode, x, y, 1'b1));
  endtask

  task automatic frame(input int mode, input int x0, input int x1, input int y0, input int y1);
    lines(mode, x0, x1, y0, y1, y1);
    vblank(mode, x0, x1, y1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0ba);
  endtask

  task automatic chk_rep(input string tag, input int n, input logic f,
                         input int x0, input int x1, input int y0, input int y1, input int c);
    chk({tag, "_reports"}, 64'(rep_n), 64'(n));
    chk({tag, "_found"}, 64'(rep_found), 64'(f));
    chk({tag, "_x_min"}, 64'(rep_x_min), 64'(x0));
    chk({tag, "_x_max"}, 64'(rep_x_max), 64'(x1));
    chk({tag, "_y_min"}, 64'(rep_y_min), 64'(y0));
    chk({tag, "_y_max"}, 64'(rep_y_max), 64'(y1));
    chk({tag, "_pix_cnt"}, 64'(rep_cnt), 64'(c));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_box_valid"}, 64'(box_valid), 64'd0);
    chk({tag, "_box_found"}, 64'(box_found), 64'd0);
    chk({tag, "_coords"}, 64'({x_min, x_max, y_min, y_max}), 64'd0);
    chk({tag, "_pix_cnt"}, 64'(pix_cnt), 64'd0);
    chk({tag, "_out"}, 64'(pack_out()), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    vin.hcount = '0; vin.vcount = '0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
    vin.hsync = 1'b0; vin.vsync = 1'b0; vin.rgb = '0;
    idle(3);
    chk_zero("reset");

    // Release mid-frame: the first vblnk rise only synchronises.
    rst = 1'b1;
    lines(0, 0, 19, 50, 59, 59);
    vblank(0, 0, 19, 59);
    chk("sync_no_report", 64'(rep_n), 64'd0);
    frame(0, 0, 19, 0, 9);
    chk_rep("empty", 1, 1'b0, 0, 0, 0, 0, 0);

    frame(1, 0, 101, 0, 101);
    chk_rep("box100", 2, 1'b1, 2, 100, 2, 100, 9801);

    frame(2, 790, 799, 590, 599);
    chk_rep("last_pix", 3, 1'b1, 799, 799, 599, 599, 1);

    frame(3, 0, 15, 15, 24);
    chk_rep("masked", 4, 1'b1, 10, 10, 20, 20, 1);

    frame(4, 0, 15, 0, 15);
    chk_rep("small_box", 5, 1'b1, 5, 9, 5, 9, 25);
    frame(0, 0, 15, 0, 15);
    chk_rep("cleared", 6, 1'b0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of an accumulating frame.
    frame(4, 0, 15, 0, 15);
    chk_rep("pre_reset", 7, 1'b1, 5, 9, 5, 9, 25);
    lines(4, 0, 15, 0, 7, 15);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("async_reset");
    @(posedge clk);
    #1;
    idle(2);
    rst = 1'b1;
    lines(4, 0, 15, 8, 15, 15);
    vblank(4, 0, 15, 15);
    chk("post_reset_sync", 64'(rep_n), 64'd7);
    frame(4, 0, 15, 0, 15);
    chk_rep("post_reset", 8, 1'b1, 5, 9, 5, 9, 25);

    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
